rand_host_responder: RTL and testbench

//  Chip-side end of the host random-number interface. Generates slow_clk from ic_clk and

---
 rtl/rand_host_responder.sv | 130 +++++++++++++
 tb/tb_rand_host_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_host_responder.sv
// Host RNG responder: divides ic_clk into slow_clk and returns 1/2/4 seed or DRBG words, one per slow period.
// First word at the slow rise after acceptance; source backpressure or zero words produce gap periods.
module rand_host_responder #(
  parameter int CLK_DIV      = 8,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                    ic_clk,
  input  logic                    top_reset,
  input  logic                    debug,
  input  logic                    rand_req,
  input  logic [2:0]              rand_req_type,
  output logic [OUTPUT_WIDTH-1:0] rand_byte,
  output logic                    rand_valid,
  output logic                    slow_clk,
  input  logic                    seed_valid,
  input  logic [OUTPUT_WIDTH-1:0] seed_data,
  output logic                    seed_ready,
  input  logic                    drbg_valid,
  input  logic [OUTPUT_WIDTH-1:0] drbg_data,
  output logic                    drbg_ready,
  output logic                    busy,
  output logic [7:0]              zero_drop_cnt
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nxt;
  logic                    slow_rise;
  logic                    use_seed;
  logic [2:0]              n_words;
  logic [2:0]              sent;
  logic [2:0]              fetched;
  logic [OUTPUT_WIDTH-1:0] hold;
  logic                    hold_valid;
  logic                    fetch_rdy;
  logic                    src_vld;
  logic [OUTPUT_WIDTH-1:0] src_dat;
  logic                    take;

  assign slow_rise = (cnt == CW'(CLK_DIV - 1));
  assign cnt_nxt   = slow_rise ? '0 : cnt + 1'b1;

  // Only one word is ever buffered; the fetched count stops over-pulling past N.
  assign fetch_rdy  = (state == ACTIVE) && !debug && !hold_valid && (fetched < n_words);
  assign seed_ready = fetch_rdy && use_seed;
  assign drbg_ready = fetch_rdy && !use_seed;
  assign src_vld    = use_seed ? seed_valid : drbg_valid;
  assign src_dat    = use_seed ? seed_data : drbg_data;
  assign take       = fetch_rdy && src_vld;

  always_ff @(posedge ic_clk or negedge top_reset) begin
    if (!top_reset) begin
      cnt      <= '0;
      slow_clk <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      slow_clk <= (cnt_nxt < CW'(CLK_DIV / 2));
    end
  end

  always_ff @(posedge ic_clk or negedge top_reset) begin
    if (!top_reset) begin
      state         <= IDLE;
      use_seed      <= 1'b0;
      n_words       <= '0;
      sent          <= '0;
      fetched       <= '0;
      hold          <= '0;
      hold_valid    <= 1'b0;
      rand_byte     <= '0;
      rand_valid    <= 1'b0;
      busy          <= 1'b0;
      zero_drop_cnt <= '0;
    end else begin
      // take and present are mutually exclusive: take needs an empty holding register
      if (take) begin
        if (src_dat == '0) begin
          if (zero_drop_cnt != 8'hFF) zero_drop_cnt <= zero_drop_cnt + 8'd1;
        end else begin
          hold       <= src_dat;
          hold_valid <= 1'b1;
          fetched    <= fetched + 3'd1;
        end
      end
      if (debug) hold_valid <= 1'b0;

      if (slow_rise) begin
        if (debug) begin
          state      <= IDLE;
          rand_valid <= 1'b0;
          busy       <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              rand_valid <= 1'b0;
              if (rand_req && (rand_req_type <= 3'd5)) begin
                use_seed <= ~rand_req_type[0];
                n_words  <= rand_req_type[2] ? 3'd4 : (rand_req_type[1] ? 3'd2 : 3'd1);
                sent     <= '0;
                fetched  <= '0;
                busy     <= 1'b1;
                state    <= ACTIVE;
              end
            end
            ACTIVE: begin
              if (hold_valid) begin
                rand_byte  <= hold;
                rand_valid <= 1'b1;
                sent       <= sent + 3'd1;
                hold_valid <= 1'b0;
                if (sent + 3'd1 == n_words) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                rand_valid <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rand_host_responder.sv
// Randomized bench for rand_host_responder with a queue-based reference model and directed scenarios.
module tb_rand_host_responder;
  localparam int CLK_DIV = 8;

  logic        ic_clk = 1'b0;
  logic        top_reset, debug, rand_req;
  logic [2:0]  rand_req_type;
  logic [15:0] rand_byte, seed_data, drbg_data;
  logic        rand_valid, slow_clk, seed_valid, seed_ready, drbg_valid, drbg_ready, busy;
  logic [7:0]  zero_drop_cnt;

  rand_host_responder #(.CLK_DIV(CLK_DIV), .OUTPUT_WIDTH(16)) dut (
    .ic_clk(ic_clk), .top_reset(top_reset), .debug(debug), .rand_req(rand_req),
    .rand_req_type(rand_req_type), .rand_byte(rand_byte), .rand_valid(rand_valid),
    .slow_clk(slow_clk), .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .drbg_valid(drbg_valid), .drbg_data(drbg_data), .drbg_ready(drbg_ready), .busy(busy),
    .zero_drop_cnt(zero_drop_cnt));

  always #5 ic_clk = ~ic_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cnt = 0, m_need = 0, m_sent = 0, m_fetched = 0, m_zero = 0;
  bit          m_slow = 0, m_active = 0, m_seed = 0, m_valid = 0, m_busy = 0, m_rise_last = 0;
  logic [15:0] m_byte = 0;
  logic [15:0] m_pend[$];
  bit          mr_rise, mr_fetch;
  logic [15:0] mr_w;

  function automatic bit exp_ready();
    return m_active && !debug && (m_pend.size() == 0) && (m_fetched < m_need);
  endfunction

  initial forever begin
    @(posedge ic_clk or negedge top_reset);
    if (!top_reset) begin
      m_cnt = 0; m_slow = 0; m_active = 0; m_seed = 0; m_valid = 0; m_busy = 0;
      m_need = 0; m_sent = 0; m_fetched = 0; m_zero = 0; m_byte = 0; m_rise_last = 0;
      m_pend.delete();
    end else begin
      mr_rise  = (m_cnt == CLK_DIV - 1);
      mr_fetch = exp_ready() && (m_seed ? seed_valid : drbg_valid);
      mr_w     = m_seed ? seed_data : drbg_data;
      if (mr_rise) begin
        if (debug) begin
          m_active = 0; m_valid = 0; m_busy = 0;
        end else if (!m_active) begin
          m_valid = 0;
          if (rand_req && rand_req_type <= 5) begin
            m_active = 1; m_busy = 1; m_seed = !rand_req_type[0];
            m_need = 1 << (rand_req_type >> 1); m_sent = 0; m_fetched = 0;
          end
        end else if (m_pend.size() > 0) begin
          m_byte = m_pend.pop_front(); m_valid = 1; m_sent++;
          if (m_sent == m_need) begin m_active = 0; m_busy = 0; end
        end else begin
          m_valid = 0;
        end
      end
      if (debug) m_pend.delete();
      if (mr_fetch) begin
        if (mr_w == 0) begin
          if (m_zero < 255) m_zero++;
        end else begin
          m_pend.push_back(mr_w); m_fetched++;
        end
      end
      m_cnt = mr_rise ? 0 : m_cnt + 1;
      m_slow = (m_cnt < CLK_DIV / 2);
      m_rise_last = mr_rise;
    end
  end

  // ---------------- compare + monitor (negedge) ----------------
  bit          checks_on = 0;
  int          rise_no = 0, acc_rise = 0;
  logic [15:0] obs[$];
  int          obs_rise[$];
  bit          prev_busy = 0, seed_rdy_seen = 0, drbg_rdy_seen = 0, busy_seen = 0, valid_seen = 0;
  logic [15:0] prev_byte = 0;

  initial forever begin
    @(negedge ic_clk);
    if (checks_on) begin
      chk("rand_byte", rand_byte, m_byte);
      chk("rand_valid", rand_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("slow_clk", slow_clk, m_slow);
      chk("zero_drop_cnt", zero_drop_cnt, m_zero);
      chk("seed_ready", seed_ready, exp_ready() && m_seed);
      chk("drbg_ready", drbg_ready, exp_ready() && !m_seed);
      chk("valid_word_nonzero", rand_valid && rand_byte == 0, 0);
      if (top_reset) chk("byte_only_at_rise", (rand_byte !== prev_byte) && !m_rise_last, 0);
    end
    if (m_rise_last) begin
      rise_no++;
      if (busy && !prev_busy) acc_rise = rise_no;
      if (rand_valid) begin obs.push_back(rand_byte); obs_rise.push_back(rise_no); end
    end
    if (seed_ready) seed_rdy_seen = 1;
    if (drbg_ready) drbg_rdy_seen = 1;
    if (busy) busy_seen = 1;
    if (rand_valid) valid_seen = 1;
    prev_busy = busy;
    prev_byte = rand_byte;
  end

  // ---------------- source drivers ----------------
  int          vld_pct = 0, zero_pct = 0;
  bit          seed_block = 1, drbg_block = 1, s_hs, d_hs;
  logic [15:0] seed_q[$], drbg_q[$];

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    if ($urandom_range(0, 99) < zero_pct) return 16'h0000;
    w = 16'($urandom);
    return (w == 0) ? 16'h0001 : w;
  endfunction

  initial begin
    seed_valid = 0; seed_data = 0; drbg_valid = 0; drbg_data = 0;
    forever begin
      @(negedge ic_clk);
      s_hs = seed_valid && seed_ready;
      d_hs = drbg_valid && drbg_ready;
      @(posedge ic_clk); #1;
      if (seed_block) seed_valid = 0;
      else if (!seed_valid || s_hs) begin
        if (seed_q.size() > 0) begin seed_valid = 1; seed_data = seed_q.pop_front(); end
        else if ($urandom_range(0, 99) < vld_pct) begin seed_valid = 1; seed_data = rand_word(); end
        else seed_valid = 0;
      end
      if (drbg_block) drbg_valid = 0;
      else if (!drbg_valid || d_hs) begin
        if (drbg_q.size() > 0) begin drbg_valid = 1; drbg_data = drbg_q.pop_front(); end
        else if ($urandom_range(0, 99) < vld_pct) begin drbg_valid = 1; drbg_data = rand_word(); end
        else drbg_valid = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge ic_clk);
    #1;
  endtask

  task automatic prep(input int vp, input int zp);
    seed_block = 1; drbg_block = 1;
    cyc(2);
    seed_q.delete(); drbg_q.delete();
    vld_pct = vp; zero_pct = zp;
    obs.delete(); obs_rise.delete();
    seed_rdy_seen = 0; drbg_rdy_seen = 0; busy_seen = 0; valid_seen = 0;
  endtask

  task automatic req(input logic [2:0] t);
    rand_req = 1; rand_req_type = t;
    for (int k = 0; k < CLK_DIV; k++) begin
      cyc(1);
      if (m_active) break;
    end
    rand_req = 0;
  endtask

  task automatic wait_idle(input bit noise);
    int k = 0;
    while ((m_active || m_valid) && k < 3000) begin
      if (noise && m_active) begin
        rand_req = 1'($urandom_range(0, 1)); rand_req_type = 3'($urandom_range(0, 7));
      end else rand_req = 0;
      cyc(1);
      k++;
    end
    rand_req = 0;
    chk("idle_timeout", k >= 3000, 0);
  endtask

  task automatic reset_pulse();
    top_reset = 0;
    cyc(3);
    top_reset = 1;
    cyc(2);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    top_reset = 1; debug = 0; rand_req = 0; rand_req_type = 0;
    #2 top_reset = 0;
    #1 checks_on = 1;
    @(negedge ic_clk);
    chk("rst_rand_byte", rand_byte, 0);
    chk("rst_rand_valid", rand_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_slow_clk", slow_clk, 0);
    chk("rst_zero_cnt", zero_drop_cnt, 0);
    cyc(2);
    top_reset = 1;
    cyc(2);

    // T1: RDRAND_32 with sources always valid
    prep(100, 0);
    drbg_q.push_back(16'h1234); drbg_q.push_back(16'h5678);
    seed_block = 0; drbg_block = 0;
    req(3);
    wait_idle(0);
    cyc(CLK_DIV);
    chk("t1_words", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("t1_word0", obs[0], 16'h1234);
      chk("t1_word1", obs[1], 16'h5678);
      chk("t1_first_rise", obs_rise[0], acc_rise + 1);
      chk("t1_second_rise", obs_rise[1], acc_rise + 2);
    end
    chk("t1_seed_ready_seen", seed_rdy_seen, 0);

    // T2: RDSEED_64 with a 3-period seed stall after acceptance
    prep(100, 0);
    seed_q.push_back(16'hA001); seed_q.push_back(16'hB002);
    seed_q.push_back(16'hC003); seed_q.push_back(16'hD004);
    drbg_block = 0;
    req(4);
    cyc(3 * CLK_DIV);
    seed_block = 0;
    wait_idle(0);
    cyc(CLK_DIV);
    chk("t2_words", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("t2_w0", obs[0], 16'hA001);
      chk("t2_w3", obs[3], 16'hD004);
      chk("t2_first_rise", obs_rise[0], acc_rise + 4);
      chk("t2_last_rise", obs_rise[3], acc_rise + 7);
    end

    // T5: reserved types are ignored
    prep(100, 0);
    seed_block = 0; drbg_block = 0;
    req(6);
    cyc(2 * CLK_DIV);
    req(7);
    cyc(2 * CLK_DIV);
    chk("t5_busy_seen", busy_seen, 0);
    chk("t5_valid_seen", valid_seen, 0);
    chk("t5_ready_seen", seed_rdy_seen || drbg_rdy_seen, 0);

    // T6: debug abort after two words, then reset mid-request
    prep(100, 0);
    seed_block = 0; drbg_block = 0;
    req(5);
    for (int k = 0; k < 500 && obs.size() < 2; k++) cyc(1);
    chk("t6_two_words", obs.size(), 2);
    debug = 1;
    repeat (CLK_DIV) @(posedge ic_clk);
    @(negedge ic_clk);
    chk("t6_dbg_valid", rand_valid, 0);
    chk("t6_dbg_busy", busy, 0);
    chk("t6_dbg_words", obs.size(), 2);
    cyc(1);
    debug = 0;
    cyc(CLK_DIV);
    prep(0, 0);
    seed_block = 0; drbg_block = 0;
    req(1);
    cyc(3);
    top_reset = 0;
    #1;
    chk("t6_rst_byte", rand_byte, 0);
    chk("t6_rst_valid", rand_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_slow", slow_clk, 0);
    chk("t6_rst_ready", drbg_ready || seed_ready, 0);
    chk("t6_rst_zero", zero_drop_cnt, 0);
    cyc(3);
    top_reset = 1;
    cyc(2);
    prep(100, 0);
    seed_block = 0; drbg_block = 0;
    req(1);
    wait_idle(0);
    chk("t6_after_rst_words", obs.size(), 1);

    // T4: random requests of every type with random source stalls and zero words
    prep(90, 10);
    seed_block = 0; drbg_block = 0;
    for (int i = 0; i < 1000; i++) begin
      vld_pct = $urandom_range(60, 100);
      req(3'($urandom_range(0, 7)));
      wait_idle(1);
    end

    // T3: zero word is discarded and counted
    reset_pulse();
    prep(0, 0);
    seed_q.push_back(16'h0000); seed_q.push_back(16'hBEEF);
    seed_block = 0; drbg_block = 0;
    req(0);
    wait_idle(0);
    cyc(CLK_DIV);
    chk("t3_words", obs.size(), 1);
    chk("t3_byte", rand_byte, 16'hBEEF);
    chk("t3_zero_cnt", zero_drop_cnt, 1);

    // zero-drop counter saturation, then debug abort
    reset_pulse();
    prep(100, 100);
    seed_block = 0; drbg_block = 0;
    req(0);
    cyc(300);
    chk("sat_zero_cnt", zero_drop_cnt, 255);
    chk("sat_valid_seen", valid_seen, 0);
    debug = 1;
    cyc(CLK_DIV + 1);
    debug = 0;
    wait_idle(0);
    chk("sat_busy_after_debug", busy, 0);

    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
